shi_load_256: RTL and testbench

SHI_LOAD_256 -- requirements
Module: shi_load_256

---
 rtl/shi_load_256_if.sv | 22 ++
 rtl/shi_load_256.sv | 90 +++++++++
 tb/tb_shi_load_256.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/shi_load_256_if.sv
// Operand-load and shift-out bus for shi_load_256: a valid/ready operand port in,
// plus a word/strobe feed to a downstream 16-stage shift register.
interface shi_load_256_if;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] din;
    logic         pause;
    logic [15:0]  word_out;
    logic         we;
    logic         busy;
    logic         done;

    modport master (
        output in_valid, din, pause,
        input  in_ready, word_out, we, busy, done
    );

    modport slave (
        input  in_valid, din, pause,
        output in_ready, word_out, we, busy, done
    );
endinterface

// File: rtl/shi_load_256.sv
// Latches a 256-bit operand and streams it as 16 x 16-bit words into a downstream
// shift register, one word per strobe, with pause stalling and a one-cycle done pulse.
module shi_load_256 #(
    parameter bit MSW_FIRST = 1'b0
) (
    input  logic           clk,
    input  logic           rst,
    shi_load_256_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [255:0]   hold_q, hold_d;

    logic [3:0]     idx;
    logic           in_ready_o;
    logic           we_o;
    logic [15:0]    word_out_o;
    logic           busy_o;
    logic           done_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs depend only on registered state plus pause, so the strobe never
    // combinationally follows in_valid/din.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_d     = hold_q;
        in_ready_o = 1'b0;
        we_o       = 1'b0;
        word_out_o = 16'd0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        idx        = MSW_FIRST ? (4'd15 - cnt_q) : cnt_q;

        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (bus.in_valid) begin
                    hold_d  = bus.din;
                    cnt_d   = 4'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                busy_o = 1'b1;
                if (!bus.pause) begin
                    we_o       = 1'b1;
                    word_out_o = hold_q[{idx, 4'b0000} +: 16];
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready = in_ready_o;
    assign bus.we       = we_o;
    assign bus.word_out = word_out_o;
    assign bus.busy     = busy_o;
    assign bus.done     = done_o;

endmodule

// File: tb/tb_shi_load_256.sv
// Scoreboard bench for shi_load_256: both emission orders run side by side against a
// strobe-count reference model and a model of the downstream 16-stage shift register.
`timescale 1ns/1ps
module tb_shi_load_256;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         pause = 1'b0;
    logic [255:0] din = '0;

    always #5 clk = ~clk;

    shi_load_256_if if0();
    shi_load_256_if if1();

    assign if0.in_valid = in_valid;
    assign if0.din      = din;
    assign if0.pause    = pause;
    assign if1.in_valid = in_valid;
    assign if1.din      = din;
    assign if1.pause    = pause;

    shi_load_256 #(.MSW_FIRST(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    shi_load_256 #(.MSW_FIRST(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference model: strobes remaining for the held operand, plus a pending done.
    int          left = 0;
    bit          mdone = 1'b0;
    int          cyc = 0;
    bit          chk_gap = 1'b0;
    int          prev_acc = -1;
    bit          mon_en = 1'b0;
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] first_w [2];
    logic [15:0] last_w  [2];
    logic [15:0] ds [2][16];

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            left  = 0;
            mdone = 1'b0;
            q0.delete();
            q1.delete();
        end else if (mdone) begin
            mdone = 1'b0;
        end else if (left > 0) begin
            if (!pause) begin
                left--;
                if (left == 0) mdone = 1'b1;
            end
        end else if (in_valid) begin
            left = 16;
            for (int k = 0; k < 16; k++) begin
                q0.push_back(din[k*16 +: 16]);
                q1.push_back(din[(15-k)*16 +: 16]);
            end
            first_w[0] = din[15:0];
            last_w[0]  = din[255:240];
            first_w[1] = din[255:240];
            last_w[1]  = din[15:0];
            if (chk_gap) begin
                if (prev_acc >= 0) check("accept_gap", cyc - prev_acc, 18);
                prev_acc = cyc;
            end
        end
    end

    task automatic mon_one(input int id, input logic ir, input logic bs, input logic dn,
                           input logic w_e, input logic [15:0] wo);
        logic [15:0] exp_w;
        bit          have;
        check($sformatf("in_ready_dut%0d", id), ir, (left == 0 && !mdone));
        check($sformatf("busy_dut%0d", id), bs, (left > 0 || mdone));
        check($sformatf("done_dut%0d", id), dn, mdone);
        check($sformatf("we_dut%0d", id), w_e, (left > 0 && !pause));
        if (w_e === 1'b1) begin
            have  = 1'b0;
            exp_w = 16'd0;
            if (id == 0) begin
                if (q0.size() > 0) begin have = 1'b1; exp_w = q0.pop_front(); end
            end else begin
                if (q1.size() > 0) begin have = 1'b1; exp_w = q1.pop_front(); end
            end
            if (!have) check($sformatf("extra_strobe_dut%0d", id), 1, 0);
            else check($sformatf("word_dut%0d", id), wo, exp_w);
            for (int i = 15; i > 0; i--) ds[id][i] = ds[id][i-1];
            ds[id][0] = wo;
        end else begin
            check($sformatf("idle_word_dut%0d", id), wo, 16'd0);
        end
        if (mdone) begin
            check($sformatf("ds_final_dut%0d", id), ds[id][15], first_w[id]);
            check($sformatf("ds_first_dut%0d", id), ds[id][0], last_w[id]);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_one(0, if0.in_ready, if0.busy, if0.done, if0.we, if0.word_out);
            mon_one(1, if1.in_ready, if1.busy, if1.done, if1.we, if1.word_out);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand from IDLE; pause for plen cycles after strobe pa (pa = 0: never).
    task automatic run_op(input logic [255:0] d, input int pa, input int plen,
                          input int exp_done, input string nm);
        int cy, strobes, pc, got;
        in_valid = 1'b1;
        din      = d;
        pause    = 1'b0;
        step();
        in_valid = 1'b0;
        din      = rand256();
        cy = 2; strobes = 0; pc = 0; got = 0;
        while (cy < 80) begin
            @(negedge clk);
            if (if0.done) begin got = cy; break; end
            if (if0.we) strobes++;
            step();
            din = rand256();
            cy++;
            pause = (pa > 0 && strobes == pa && pc < plen);
            if (pause) pc++;
        end
        pause = 1'b0;
        check({nm, "_done_cycle"}, got, exp_done);
        check({nm, "_strobes"}, strobes, 16);
        step();
    endtask

    logic [255:0] d0;

    initial begin
        int strobes, t, n_we, n_done;

        rst = 1'b1;
        step();
        mon_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", if0.in_ready, 1'b1);
        check("rst_word_out", if1.word_out, 16'd0);
        step();

        for (int k = 0; k < 15; k++) d0[k*16 +: 16] = 16'(k + 1);
        d0[255:240] = 16'hF00F;
        run_op(d0, 0, 0, 18, "basic");
        check("ds_final_lsw_first", ds[0][15], 16'h0001);
        check("ds_final_msw_first", ds[1][15], 16'hF00F);

        run_op(rand256(), 5, 3, 21, "pause");

        chk_gap  = 1'b1;
        prev_acc = -1;
        in_valid = 1'b1;
        repeat (60) begin
            din = rand256();
            step();
        end
        in_valid = 1'b0;
        chk_gap  = 1'b0;
        repeat (25) step();

        in_valid = 1'b1;
        din      = rand256();
        step();
        in_valid = 1'b0;
        strobes = 0;
        t = 0;
        while (strobes < 7 && t < 40) begin
            @(negedge clk);
            if (if0.we) strobes++;
            step();
            t++;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready", if0.in_ready, 1'b1);
        check("abort_busy", if0.busy, 1'b0);
        n_we = 0;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (if0.we || if1.we) n_we++;
            if (if0.done || if1.done) n_done++;
            step();
        end
        check("abort_no_strobes", n_we, 0);
        check("abort_no_done", n_done, 0);
        run_op(rand256(), 0, 0, 18, "after_rst");

        repeat (900) begin
            in_valid = ($urandom_range(0, 2) != 0);
            din      = rand256();
            pause    = ($urandom_range(0, 3) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            step();
        end
        in_valid = 1'b0;
        pause    = 1'b0;
        rst      = 1'b0;
        repeat (25) step();
        check("queue0_drained", q0.size(), 0);
        check("queue1_drained", q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
